// File: rtl/nrisc_interrupt_ctrl_pkg.sv
// Shared constants, FSM state encoding and vector address helper for the
// nrisc interrupt controller.
package nrisc_interrupt_ctrl_pkg;

    localparam int unsigned N_IRQ_DEF        = 8;
    localparam int unsigned IDX_W            = 3;
    localparam logic [7:0]  VECTOR_BASE_DEF  = 8'h10;
    localparam int unsigned VECTOR_SHIFT_DEF = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StGuard = 2'd2
    } irq_state_e;

    // Vector address wraps at 8 bits.
    function automatic logic [7:0] vector_addr(input logic [7:0]       base,
                                               input logic [IDX_W-1:0] idx,
                                               input int unsigned      shift);
        return base + (8'(idx) << shift);
    endfunction

endpackage

// File: rtl/nrisc_irq_sync_edge.sv
// One IRQ line: two-flop synchroniser followed by a rising-edge detector.
module nrisc_irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic edge_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = irq_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/nrisc_interrupt_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask/GIE gating, fixed-priority
// nested arbitration and a one-cycle vector request into the PC controller.
module nrisc_interrupt_ctrl
    import nrisc_interrupt_ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ        = N_IRQ_DEF,
    parameter logic [7:0]  VECTOR_BASE  = VECTOR_BASE_DEF,
    parameter int unsigned VECTOR_SHIFT = VECTOR_SHIFT_DEF,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned MAX_NEST     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] IRQ_in,
    input  logic [N_IRQ-1:0] MASK_in,
    input  logic             MASK_we,
    input  logic             GIE_set,
    input  logic             GIE_clr,
    input  logic [1:0]       CORE_PC_ctrl,
    input  logic [1:0]       CORE_STACK_ctrl,
    input  logic             CORE_RETI,
    output logic [7:0]       INTERRUPT_ch,
    output logic             INTERRUPT_flag,
    output logic [N_IRQ-1:0] INTERRUPT_pending,
    output logic [N_IRQ-1:0] INTERRUPT_inservice
);

    irq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       ch_q, ch_d;
    logic [7:0]       guard_q, guard_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] inservice_q, inservice_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic             gie_q, gie_d;

    logic [N_IRQ-1:0] edges;
    logic [N_IRQ-1:0] req;
    logic [N_IRQ-1:0] pending_clr;
    logic [N_IRQ-1:0] inservice_set;
    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic             ins_found;
    logic [IDX_W-1:0] ins_idx;
    logic [7:0]       ins_cnt;
    logic             cand_valid;
    logic             slot_free;
    logic             abort;
    logic             flag;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        nrisc_irq_sync_edge u_sync_edge (
            .clk    (clk),
            .rst    (rst),
            .irq_i  (IRQ_in[g]),
            .edge_o (edges[g])
        );
    end

    assign req = pending_q & mask_q;

    // Highest-priority request, lowest active in-service level and nesting depth.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        ins_found  = 1'b0;
        ins_idx    = '0;
        ins_cnt    = 8'd0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
            end
            if (inservice_q[i]) begin
                ins_found = 1'b1;
                ins_idx   = IDX_W'(i);
                ins_cnt   = ins_cnt + 8'd1;
            end
        end
    end

    assign cand_valid = cand_found & gie_q & (~ins_found | (cand_idx < ins_idx)) &
                        (ins_cnt < 8'(MAX_NEST));

    assign slot_free = (CORE_PC_ctrl == 2'b00) & (CORE_STACK_ctrl == 2'b00) & ~CORE_RETI;

    always_comb begin
        gie_d = gie_q;
        if (GIE_clr) begin
            gie_d = 1'b0;
        end else if (GIE_set) begin
            gie_d = 1'b1;
        end
        mask_d = MASK_we ? MASK_in : mask_q;

        state_d       = state_q;
        idx_d         = idx_q;
        ch_d          = ch_q;
        guard_d       = guard_q;
        pending_clr   = '0;
        inservice_set = '0;
        abort         = 1'b0;
        flag          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cand_valid) begin
                    idx_d   = cand_idx;
                    ch_d    = vector_addr(VECTOR_BASE, cand_idx, VECTOR_SHIFT);
                    state_d = StArm;
                end
            end
            StArm: begin
                // The locked line is dropped if it is disabled in this very cycle.
                abort = GIE_clr | ~mask_d[idx_q];
                if (abort) begin
                    state_d = StIdle;
                end else if (slot_free) begin
                    flag                 = 1'b1;
                    pending_clr[idx_q]   = 1'b1;
                    inservice_set[idx_q] = 1'b1;
                    guard_d              = 8'(GUARD_CYCLES);
                    state_d              = (GUARD_CYCLES == 0) ? StIdle : StGuard;
                end
            end
            StGuard: begin
                if (guard_q <= 8'd1) begin
                    guard_d = 8'd0;
                    state_d = StIdle;
                end else begin
                    guard_d = guard_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A fresh edge beats a same-cycle clear so the new request is not lost.
        pending_d   = (pending_q & ~pending_clr) | edges;
        inservice_d = inservice_q | inservice_set;
        if (CORE_RETI && ins_found) begin
            inservice_d[ins_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            ch_q        <= 8'h00;
            guard_q     <= 8'd0;
            pending_q   <= '0;
            inservice_q <= '0;
            mask_q      <= '0;
            gie_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ch_q        <= ch_d;
            guard_q     <= guard_d;
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
            mask_q      <= mask_d;
            gie_q       <= gie_d;
        end
    end

    assign INTERRUPT_flag      = flag & ~rst;
    assign INTERRUPT_ch        = ch_q;
    assign INTERRUPT_pending   = pending_q;
    assign INTERRUPT_inservice = inservice_q;

endmodule

// File: tb/tb_nrisc_interrupt_ctrl.sv
// Directed self-checking bench for nrisc_interrupt_ctrl.
module tb_nrisc_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] IRQ_in;
    logic [7:0] MASK_in;
    logic       MASK_we;
    logic       GIE_set;
    logic       GIE_clr;
    logic [1:0] CORE_PC_ctrl;
    logic [1:0] CORE_STACK_ctrl;
    logic       CORE_RETI;
    logic [7:0] INTERRUPT_ch;
    logic       INTERRUPT_flag;
    logic [7:0] INTERRUPT_pending;
    logic [7:0] INTERRUPT_inservice;

    int checks = 0;
    int errors = 0;

    nrisc_interrupt_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .IRQ_in              (IRQ_in),
        .MASK_in             (MASK_in),
        .MASK_we             (MASK_we),
        .GIE_set             (GIE_set),
        .GIE_clr             (GIE_clr),
        .CORE_PC_ctrl        (CORE_PC_ctrl),
        .CORE_STACK_ctrl     (CORE_STACK_ctrl),
        .CORE_RETI           (CORE_RETI),
        .INTERRUPT_ch        (INTERRUPT_ch),
        .INTERRUPT_flag      (INTERRUPT_flag),
        .INTERRUPT_pending   (INTERRUPT_pending),
        .INTERRUPT_inservice (INTERRUPT_inservice)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_flag(input int max_cycles, output bit got, output logic [7:0] ch,
                             output int cycles);
        got    = 1'b0;
        ch     = 8'h00;
        cycles = 0;
        for (int n = 1; n <= max_cycles && !got; n++) begin
            tick();
            #1;
            if (INTERRUPT_flag) begin
                got    = 1'b1;
                ch     = INTERRUPT_ch;
                cycles = n;
            end
        end
    endtask

    task automatic quiet(input int n, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            #1;
            if (INTERRUPT_flag) seen = 1'b1;
        end
    endtask

    task automatic reti_pulse();
        tick();
        CORE_RETI = 1'b1;
        tick();
        CORE_RETI = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; IRQ_in = 8'h00; MASK_in = 8'h00; MASK_we = 1'b0;
        GIE_set = 1'b0; GIE_clr = 1'b0; CORE_PC_ctrl = 2'b00; CORE_STACK_ctrl = 2'b00;
        CORE_RETI = 1'b0;
        tick(); tick(); #1;
        checks++; if (INTERRUPT_flag !== 1'b0) begin errors++;
            $display("FAIL reset_flag: got %b want 0", INTERRUPT_flag); end
        checks++; if (INTERRUPT_ch !== 8'h00) begin errors++;
            $display("FAIL reset_ch: got %h want 00", INTERRUPT_ch); end
        checks++; if (INTERRUPT_pending !== 8'h00) begin errors++;
            $display("FAIL reset_pending: got %h want 00", INTERRUPT_pending); end
        checks++; if (INTERRUPT_inservice !== 8'h00) begin errors++;
            $display("FAIL reset_inservice: got %h want 00", INTERRUPT_inservice); end
        tick();
        rst = 1'b0;
        tick();
        MASK_in = 8'hFF; MASK_we = 1'b1; GIE_set = 1'b1;
        tick();
        MASK_we = 1'b0; GIE_set = 1'b0;
    endtask

    task automatic test_single();
        bit got; bit seen; logic [7:0] ch; int cyc;
        tick();
        IRQ_in[3] = 1'b1;
        wait_flag(10, got, ch, cyc);
        checks++; if (!got || cyc != 4) begin errors++;
            $display("FAIL single_latency: got flag=%b after %0d cycles want 4", got, cyc); end
        checks++; if (ch !== 8'h1C) begin errors++;
            $display("FAIL single_ch: got %h want 1c", ch); end
        tick(); #1;
        checks++; if (INTERRUPT_flag !== 1'b0) begin errors++;
            $display("FAIL single_one_cycle: flag got %b want 0", INTERRUPT_flag); end
        checks++; if (INTERRUPT_pending !== 8'h00 || INTERRUPT_inservice !== 8'h08) begin
            errors++; $display("FAIL single_state: pend %h ins %h want 00 08",
                               INTERRUPT_pending, INTERRUPT_inservice); end
        quiet(10, seen);
        checks++; if (seen) begin errors++;
            $display("FAIL single_level_held: got re-request want none"); end
        IRQ_in = 8'h00;
        reti_pulse(); #1;
        checks++; if (INTERRUPT_inservice !== 8'h00) begin errors++;
            $display("FAIL single_reti: ins got %h want 00", INTERRUPT_inservice); end
    endtask

    task automatic test_priority();
        bit got; bit seen; logic [7:0] ch; int cyc;
        tick();
        IRQ_in = 8'h24;
        wait_flag(10, got, ch, cyc);
        checks++; if (!got || ch !== 8'h18) begin errors++;
            $display("FAIL prio_first: got flag=%b ch=%h want 1 18", got, ch); end
        tick(); #1;
        checks++; if (INTERRUPT_pending !== 8'h20 || INTERRUPT_inservice !== 8'h04) begin
            errors++; $display("FAIL prio_state: pend %h ins %h want 20 04",
                               INTERRUPT_pending, INTERRUPT_inservice); end
        quiet(6, seen);
        checks++; if (seen) begin errors++;
            $display("FAIL prio_blocked: got flag want none while level 2 in service"); end
        reti_pulse();
        wait_flag(10, got, ch, cyc);
        checks++; if (!got || ch !== 8'h24) begin errors++;
            $display("FAIL prio_second: got flag=%b ch=%h want 1 24", got, ch); end
        IRQ_in = 8'h00;
        reti_pulse(); #1;
        checks++; if (INTERRUPT_inservice !== 8'h00) begin errors++;
            $display("FAIL prio_cleanup: ins got %h want 00", INTERRUPT_inservice); end
    endtask

    task automatic test_nesting();
        bit got; bit seen; logic [7:0] ch; int cyc;
        tick();
        IRQ_in[2] = 1'b1;
        wait_flag(10, got, ch, cyc);
        tick();
        IRQ_in[4] = 1'b1;
        quiet(8, seen);
        checks++; if (seen || INTERRUPT_pending !== 8'h10) begin errors++;
            $display("FAIL nest_lower_blocked: flag seen=%b pend %h want 0 10",
                     seen, INTERRUPT_pending); end
        IRQ_in[1] = 1'b1;
        wait_flag(10, got, ch, cyc);
        checks++; if (!got || ch !== 8'h14) begin errors++;
            $display("FAIL nest_higher: got flag=%b ch=%h want 1 14", got, ch); end
        tick(); #1;
        checks++; if (INTERRUPT_inservice !== 8'h06) begin errors++;
            $display("FAIL nest_inservice: got %h want 06", INTERRUPT_inservice); end
        IRQ_in = 8'h00;
        reti_pulse();
        reti_pulse();
        wait_flag(10, got, ch, cyc);
        checks++; if (!got || ch !== 8'h20) begin errors++;
            $display("FAIL nest_unblocked: got flag=%b ch=%h want 1 20", got, ch); end
        reti_pulse();
    endtask

    task automatic test_back_to_back();
        bit got; logic [7:0] ch; int cyc;
        tick();
        IRQ_in[6] = 1'b1;
        tick(); tick();
        IRQ_in[2] = 1'b1;
        wait_flag(10, got, ch, cyc);
        checks++; if (!got || ch !== 8'h28 || cyc != 2) begin errors++;
            $display("FAIL b2b_first: flag=%b ch=%h cyc=%0d want 1 28 2", got, ch, cyc); end
        wait_flag(10, got, ch, cyc);
        checks++; if (!got || ch !== 8'h18 || cyc != 4) begin errors++;
            $display("FAIL b2b_spacing: flag=%b ch=%h cyc=%0d want 1 18 4", got, ch, cyc); end
        IRQ_in = 8'h00;
        reti_pulse();
        reti_pulse(); #1;
        checks++; if (INTERRUPT_inservice !== 8'h00) begin errors++;
            $display("FAIL b2b_cleanup: ins got %h want 00", INTERRUPT_inservice); end
    endtask

    task automatic test_slot_busy();
        bit seen;
        tick();
        CORE_STACK_ctrl = 2'b01;
        IRQ_in[6] = 1'b1;
        quiet(6, seen);
        checks++; if (seen || INTERRUPT_ch !== 8'h28) begin errors++;
            $display("FAIL busy_hold: flag seen=%b ch=%h want 0 28", seen, INTERRUPT_ch); end
        tick();
        CORE_STACK_ctrl = 2'b00;
        #1;
        checks++; if (INTERRUPT_flag !== 1'b1) begin errors++;
            $display("FAIL busy_release: flag got %b want 1", INTERRUPT_flag); end
        tick();
        IRQ_in = 8'h00;
        #1;
        checks++; if (INTERRUPT_flag !== 1'b0 || INTERRUPT_inservice !== 8'h40) begin errors++;
            $display("FAIL busy_after: flag %b ins %h want 0 40",
                     INTERRUPT_flag, INTERRUPT_inservice); end
        reti_pulse();
    endtask

    task automatic test_abort();
        bit got; bit seen; logic [7:0] ch; int cyc;
        tick();
        CORE_STACK_ctrl = 2'b01;
        IRQ_in[7] = 1'b1;
        quiet(6, seen);
        tick();
        CORE_STACK_ctrl = 2'b00; MASK_in = 8'h7F; MASK_we = 1'b1;
        #1;
        checks++; if (INTERRUPT_flag !== 1'b0) begin errors++;
            $display("FAIL abort_mask: flag got %b want 0", INTERRUPT_flag); end
        tick();
        MASK_we = 1'b0;
        #1;
        checks++; if (INTERRUPT_flag !== 1'b0 || INTERRUPT_pending !== 8'h80) begin errors++;
            $display("FAIL abort_kept: flag %b pend %h want 0 80",
                     INTERRUPT_flag, INTERRUPT_pending); end
        MASK_in = 8'hFF; MASK_we = 1'b1;
        tick();
        MASK_we = 1'b0;
        wait_flag(10, got, ch, cyc);
        checks++; if (!got || ch !== 8'h2C) begin errors++;
            $display("FAIL abort_reissue: flag=%b ch=%h want 1 2c", got, ch); end
        IRQ_in = 8'h00;
        reti_pulse();
    endtask

    task automatic test_max_nest();
        bit got; bit seen; logic [7:0] ch; int cyc;
        int         lines [3] = '{5, 3, 1};
        logic [7:0] vecs  [3] = '{8'h24, 8'h1C, 8'h14};
        for (int k = 0; k < 3; k++) begin
            tick();
            IRQ_in[lines[k]] = 1'b1;
            wait_flag(10, got, ch, cyc);
            checks++; if (!got || ch !== vecs[k]) begin errors++;
                $display("FAIL maxnest_fill%0d: flag=%b ch=%h want 1 %h", k, got, ch, vecs[k]);
            end
        end
        tick();
        IRQ_in[0] = 1'b1;
        quiet(8, seen);
        checks++; if (seen || INTERRUPT_pending !== 8'h01 || INTERRUPT_inservice !== 8'h2A) begin
            errors++; $display("FAIL maxnest_hold: seen=%b pend %h ins %h want 0 01 2a",
                               seen, INTERRUPT_pending, INTERRUPT_inservice); end
        reti_pulse();
        wait_flag(10, got, ch, cyc);
        checks++; if (!got || ch !== 8'h10) begin errors++;
            $display("FAIL maxnest_release: flag=%b ch=%h want 1 10", got, ch); end
        IRQ_in = 8'h00;
        reti_pulse(); reti_pulse(); reti_pulse(); #1;
        checks++; if (INTERRUPT_inservice !== 8'h00) begin errors++;
            $display("FAIL maxnest_drain: ins got %h want 00", INTERRUPT_inservice); end
        reti_pulse(); #1;
        checks++; if (INTERRUPT_inservice !== 8'h00 || INTERRUPT_pending !== 8'h00) begin
            errors++; $display("FAIL reti_empty: ins %h pend %h want 00 00",
                               INTERRUPT_inservice, INTERRUPT_pending); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        tick();
        CORE_STACK_ctrl = 2'b01;
        IRQ_in[6] = 1'b1;
        quiet(6, seen);
        checks++; if (INTERRUPT_pending !== 8'h40) begin errors++;
            $display("FAIL rstmid_pending: got %h want 40", INTERRUPT_pending); end
        tick();
        rst = 1'b1; CORE_STACK_ctrl = 2'b00; IRQ_in = 8'h00;
        #1;
        checks++; if (INTERRUPT_flag !== 1'b0) begin errors++;
            $display("FAIL rstmid_flag_in_reset: got %b want 0", INTERRUPT_flag); end
        tick(); #1;
        checks++; if (INTERRUPT_flag !== 1'b0 || INTERRUPT_ch !== 8'h00 ||
                      INTERRUPT_pending !== 8'h00) begin errors++;
            $display("FAIL rstmid_state: flag %b ch %h pend %h want 0 00 00",
                     INTERRUPT_flag, INTERRUPT_ch, INTERRUPT_pending); end
        rst = 1'b0;
        tick();
        IRQ_in[6] = 1'b1;
        quiet(8, seen);
        checks++; if (seen || INTERRUPT_pending !== 8'h40) begin errors++;
            $display("FAIL rstmid_mask_cleared: seen=%b pend %h want 0 40",
                     seen, INTERRUPT_pending); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_back_to_back();
        test_slot_busy();
        test_abort();
        test_max_nest();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
